// File: rtl/pkfb_push_arbiter.sv
// Packet-atomic round-robin arbiter sharing the packet-FIFO push bus between four sources.
// Frames SOF/EOF, truncates over-long packets and aborts packets whose push overflowed.
module pkfb_push_arbiter #(
    parameter int MAX_WORDS = 256
) (
    input  logic         Sys_PKfb_Clk,
    input  logic         Sys_PKfb_Rst,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_data,
    input  logic [3:0]   req_last,
    output logic [3:0]   req_ready,
    input  logic [3:0]   req_en,
    output logic [31:0]  FB_PKfbData,
    output logic [3:0]   FB_PKfbPush,
    output logic         FB_PKfbSOF,
    output logic         FB_PKfbEOF,
    input  logic         FB_PKfbOverflow,
    input  logic [3:0]   ovf_clr,
    output logic [3:0]   ovf_sticky,
    output logic [3:0]   pkt_done,
    output logic [3:0]   pkt_drop
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

    state_t        state_reg;
    logic [1:0]    grant_reg;
    logic [1:0]    rr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   data_reg;
    logic [3:0]    push_reg;
    logic          sof_reg;
    logic          eof_reg;
    logic [3:0]    sticky_reg;
    logic [3:0]    done_reg;
    logic [3:0]    drop_reg;

    logic [31:0]   req_word [4];
    logic [3:0]    cand;
    logic [3:0]    grant_onehot;
    logic          arb_hit;
    logic [1:0]    arb_idx;
    logic          sel_valid;
    logic          sel_last;
    logic          accept;
    logic          ovf_hit;
    logic          abort;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign req_word[gi]  = req_data[32*gi +: 32];
            assign req_ready[gi] = (state_reg != IDLE) && (grant_reg == 2'(gi));
        end
    endgenerate

    assign cand         = req_valid & req_en;
    assign grant_onehot = 4'b0001 << grant_reg;
    assign sel_valid    = req_valid[grant_reg];
    assign sel_last     = req_last[grant_reg];
    assign accept       = (state_reg != IDLE) && sel_valid;

    // Overflow only aborts the packet still in flight; an overflowed EOF push has nothing left to abort.
    assign ovf_hit = FB_PKfbOverflow && (push_reg != 4'b0000);
    assign abort   = ovf_hit && !eof_reg && (state_reg == XFER) && (push_reg == grant_onehot);

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = rr_ptr_reg;
        for (int k = 1; k <= 4; k++) begin
            if (!arb_hit && cand[rr_ptr_reg + 2'(k)]) begin
                arb_hit = 1'b1;
                arb_idx = rr_ptr_reg + 2'(k);
            end
        end
    end

    always_ff @(posedge Sys_PKfb_Clk) begin
        if (Sys_PKfb_Rst) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'd0;
            rr_ptr_reg <= 2'd3;
            count_reg  <= '0;
            data_reg   <= 32'd0;
            push_reg   <= 4'b0000;
            sof_reg    <= 1'b0;
            eof_reg    <= 1'b0;
            sticky_reg <= 4'b0000;
            done_reg   <= 4'b0000;
            drop_reg   <= 4'b0000;
        end else begin
            push_reg   <= 4'b0000;
            sof_reg    <= 1'b0;
            eof_reg    <= 1'b0;
            done_reg   <= 4'b0000;
            drop_reg   <= 4'b0000;
            sticky_reg <= (sticky_reg & ~ovf_clr) | (ovf_hit ? push_reg : 4'b0000);
            case (state_reg)
                IDLE: begin
                    if (arb_hit) begin
                        grant_reg  <= arb_idx;
                        rr_ptr_reg <= arb_idx;
                        count_reg  <= '0;
                        state_reg  <= XFER;
                    end
                end
                XFER: begin
                    if (abort) begin
                        if (accept && sel_last) begin
                            drop_reg  <= grant_onehot;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= DROP;
                        end
                    end else if (accept) begin
                        data_reg  <= req_word[grant_reg];
                        push_reg  <= grant_onehot;
                        sof_reg   <= (count_reg == '0);
                        eof_reg   <= sel_last || (count_reg == LAST_CNT);
                        count_reg <= count_reg + 1'b1;
                        if (sel_last) begin
                            done_reg  <= grant_onehot;
                            state_reg <= IDLE;
                        end else if (count_reg == LAST_CNT) begin
                            state_reg <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && sel_last) begin
                        drop_reg  <= grant_onehot;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign FB_PKfbData = data_reg;
    assign FB_PKfbPush = push_reg;
    assign FB_PKfbSOF  = sof_reg;
    assign FB_PKfbEOF  = eof_reg;
    assign ovf_sticky  = sticky_reg;
    assign pkt_done    = done_reg;
    assign pkt_drop    = drop_reg;
endmodule

// File: tb/tb_pkfb_push_arbiter.sv
// Directed bench for pkfb_push_arbiter (MAX_WORDS=4): framing, round-robin,
// overflow abort, truncation, mid-packet reset and sticky clear priority.
module tb_pkfb_push_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic [3:0]   req_en;
    logic [31:0]  FB_PKfbData;
    logic [3:0]   FB_PKfbPush;
    logic         FB_PKfbSOF;
    logic         FB_PKfbEOF;
    logic         FB_PKfbOverflow;
    logic [3:0]   ovf_clr;
    logic [3:0]   ovf_sticky;
    logic [3:0]   pkt_done;
    logic [3:0]   pkt_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  push;
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } push_t;
    typedef struct {
        int         cyc;
        logic [3:0] bits;
    } ev_t;

    push_t       plog[$];
    ev_t         done_log[$];
    ev_t         drop_log[$];
    logic [31:0] wq[4][$];
    logic        lq[4][$];

    pkfb_push_arbiter #(.MAX_WORDS(4)) dut (
        .Sys_PKfb_Clk    (clk),
        .Sys_PKfb_Rst    (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .req_en          (req_en),
        .FB_PKfbData     (FB_PKfbData),
        .FB_PKfbPush     (FB_PKfbPush),
        .FB_PKfbSOF      (FB_PKfbSOF),
        .FB_PKfbEOF      (FB_PKfbEOF),
        .FB_PKfbOverflow (FB_PKfbOverflow),
        .ovf_clr         (ovf_clr),
        .ovf_sticky      (ovf_sticky),
        .pkt_done        (pkt_done),
        .pkt_drop        (pkt_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (FB_PKfbPush != 4'b0000) begin
                plog.push_back('{cyc: cyc, push: FB_PKfbPush, data: FB_PKfbData, sof: FB_PKfbSOF, eof: FB_PKfbEOF});
                $display("[%0d] push fifo=%b data=%h sof=%b eof=%b", cyc, FB_PKfbPush, FB_PKfbData, FB_PKfbSOF, FB_PKfbEOF);
            end
            if (pkt_done != 4'b0000) done_log.push_back('{cyc: cyc, bits: pkt_done});
            if (pkt_drop != 4'b0000) drop_log.push_back('{cyc: cyc, bits: pkt_drop});
        end
    end

    function automatic void drive();
        for (int i = 0; i < 4; i++) begin
            if (wq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[32*i +: 32] = wq[i][0];
                req_last[i]          = lq[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endfunction

    task automatic tick();
        logic [3:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && wq[i].size() > 0) begin
                void'(wq[i].pop_front());
                void'(lq[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic send_pkt(input int r, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            wq[r].push_back(base + 32'(k));
            lq[r].push_back(k == n - 1);
        end
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            wq[i].delete();
            lq[i].delete();
        end
        plog.delete();
        done_log.delete();
        drop_log.delete();
        drive();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) tick();
        rst = 1'b0;
        plog.delete();
        done_log.delete();
        drop_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) tick();
        n_checks++;
        if ({FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, req_ready, ovf_sticky, pkt_done, pkt_drop} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: push=%b sof=%b eof=%b ready=%b sticky=%b done=%b drop=%b, required all 0",
                     FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, req_ready, ovf_sticky, pkt_done, pkt_drop);
        end
        n_checks++;
        if (FB_PKfbData !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", FB_PKfbData);
        end
        rst = 1'b0;
        // Valid requester without arbitration enable must never be granted.
        req_en = 4'b1110;
        send_pkt(0, 32'hEE, 1);
        repeat (4) tick();
        n_checks++;
        if (req_ready !== 4'b0000 || plog.size() != 0) begin
            n_fail++;
            $display("FAIL en_gate: ready=%b pushes=%0d, required ready=0000 pushes=0", req_ready, plog.size());
        end
        req_en = 4'b1111;
        apply_reset();
    endtask

    task automatic test_single_packet();
        logic [31:0] exp_data[3] = '{32'hA0, 32'hA1, 32'hA2};
        send_pkt(0, 32'hA0, 3);
        repeat (10) tick();
        n_checks++;
        if (plog.size() != 3) begin
            n_fail++;
            $display("FAIL single_count: got %0d pushes, required 3", plog.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (plog[k].push !== 4'b0001 || plog[k].data !== exp_data[k] || plog[k].sof !== (k == 0) || plog[k].eof !== (k == 2)) begin
                    n_fail++;
                    $display("FAIL single_word%0d: push=%b data=%h sof=%b eof=%b, required push=0001 data=%h sof=%b eof=%b",
                             k, plog[k].push, plog[k].data, plog[k].sof, plog[k].eof, exp_data[k], k == 0, k == 2);
                end
            end
            n_checks++;
            if (plog[1].cyc != plog[0].cyc + 1 || plog[2].cyc != plog[0].cyc + 2) begin
                n_fail++;
                $display("FAIL single_b2b: cycles %0d %0d %0d, required consecutive", plog[0].cyc, plog[1].cyc, plog[2].cyc);
            end
            n_checks++;
            if (done_log.size() != 1 || done_log[0].bits !== 4'b0001 || done_log[0].cyc != plog[2].cyc || drop_log.size() != 0) begin
                n_fail++;
                $display("FAIL single_done: done events=%0d drop events=%0d, required one 0001 done aligned with EOF", done_log.size(), drop_log.size());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data[8] = '{32'h00, 32'h01, 32'h20, 32'h21, 32'h02, 32'h03, 32'h22, 32'h23};
        logic [3:0]  exp_push[8] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0100};
        apply_reset();
        send_pkt(0, 32'h00, 2);
        send_pkt(0, 32'h02, 2);
        send_pkt(2, 32'h20, 2);
        send_pkt(2, 32'h22, 2);
        repeat (20) tick();
        n_checks++;
        if (plog.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count: got %0d pushes, required 8", plog.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (plog[k].push !== exp_push[k] || plog[k].data !== exp_data[k] || plog[k].sof !== (k % 2 == 0) || plog[k].eof !== (k % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL rr_word%0d: push=%b data=%h sof=%b eof=%b, required push=%b data=%h sof=%b eof=%b",
                             k, plog[k].push, plog[k].data, plog[k].sof, plog[k].eof, exp_push[k], exp_data[k], k % 2 == 0, k % 2 == 1);
                end
            end
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if (plog[2*p+2].cyc - plog[2*p+1].cyc != 2) begin
                    n_fail++;
                    $display("FAIL rr_gap%0d: gap %0d cycles, required 2", p, plog[2*p+2].cyc - plog[2*p+1].cyc);
                end
            end
        end
        n_checks++;
        if (done_log.size() != 4) begin
            n_fail++;
            $display("FAIL rr_done: got %0d done pulses, required 4", done_log.size());
        end
    endtask

    task automatic test_overflow_abort();
        int n = 0;
        clear_all();
        send_pkt(1, 32'h10, 4);
        send_pkt(1, 32'h18, 2);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (FB_PKfbPush != 4'b0000) n++;
            FB_PKfbOverflow = (FB_PKfbPush != 4'b0000) && (n == 2);
        end
        FB_PKfbOverflow = 1'b0;
        n_checks++;
        if (ovf_sticky !== 4'b0010) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b, required 0010", ovf_sticky);
        end
        n_checks++;
        if (plog.size() != 4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d pushes, required 4", plog.size());
        end else begin
            n_checks++;
            if (plog[0].data !== 32'h10 || plog[1].data !== 32'h11 || plog[2].data !== 32'h18 || plog[3].data !== 32'h19) begin
                n_fail++;
                $display("FAIL ovf_data: got %h %h %h %h, required 10 11 18 19", plog[0].data, plog[1].data, plog[2].data, plog[3].data);
            end
            n_checks++;
            if ({plog[0].sof, plog[1].sof, plog[2].sof, plog[3].sof} !== 4'b1010 ||
                {plog[0].eof, plog[1].eof, plog[2].eof, plog[3].eof} !== 4'b0001 ||
                plog[2].push !== 4'b0010) begin
                n_fail++;
                $display("FAIL ovf_framing: sof=%b%b%b%b eof=%b%b%b%b, required sof=1010 eof=0001",
                         plog[0].sof, plog[1].sof, plog[2].sof, plog[3].sof, plog[0].eof, plog[1].eof, plog[2].eof, plog[3].eof);
            end
            n_checks++;
            if (drop_log.size() != 1 || drop_log[0].bits !== 4'b0010 || drop_log[0].cyc >= plog[2].cyc) begin
                n_fail++;
                $display("FAIL ovf_drop: got %0d drop pulses, required one 0010 before next packet", drop_log.size());
            end
            n_checks++;
            if (done_log.size() != 1 || done_log[0].bits !== 4'b0010) begin
                n_fail++;
                $display("FAIL ovf_done: got %0d done pulses, required one 0010", done_log.size());
            end
        end
    endtask

    task automatic test_max_words();
        clear_all();
        send_pkt(3, 32'h30, 6);
        repeat (14) tick();
        n_checks++;
        if (plog.size() != 4) begin
            n_fail++;
            $display("FAIL max_count: got %0d pushes, required 4", plog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (plog[k].push !== 4'b1000 || plog[k].data !== 32'h30 + 32'(k) || plog[k].sof !== (k == 0) || plog[k].eof !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL max_word%0d: push=%b data=%h sof=%b eof=%b, required push=1000 data=%h sof=%b eof=%b",
                             k, plog[k].push, plog[k].data, plog[k].sof, plog[k].eof, 32'h30 + 32'(k), k == 0, k == 3);
                end
            end
            n_checks++;
            if (drop_log.size() != 1 || drop_log[0].bits !== 4'b1000 || drop_log[0].cyc <= plog[3].cyc || done_log.size() != 0) begin
                n_fail++;
                $display("FAIL max_drop: drop pulses=%0d done pulses=%0d, required one 1000 drop and no done", drop_log.size(), done_log.size());
            end
        end
        n_checks++;
        if (wq[3].size() != 0) begin
            n_fail++;
            $display("FAIL max_consume: %0d words left, required 0", wq[3].size());
        end
    endtask

    task automatic test_reset_midpacket();
        int pre_pushes;
        logic pre_eof;
        clear_all();
        send_pkt(2, 32'h50, 5);
        for (int c = 0; c < 20 && plog.size() == 0; c++) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (FB_PKfbPush !== 4'b0000 || FB_PKfbSOF !== 1'b0 || FB_PKfbEOF !== 1'b0 || req_ready !== 4'b0000 || ovf_sticky !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_outputs: push=%b sof=%b eof=%b ready=%b sticky=%b, required all 0",
                     FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, req_ready, ovf_sticky);
        end
        pre_pushes = plog.size();
        pre_eof = (pre_pushes > 0) ? plog[0].eof : 1'b1;
        n_checks++;
        if (pre_pushes != 1 || pre_eof !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abandon: pushes=%0d eof=%b, required 1 push without EOF", pre_pushes, pre_eof);
        end
        clear_all();
        rst = 1'b0;
        send_pkt(2, 32'h70, 1);
        send_pkt(0, 32'h60, 2);
        repeat (10) tick();
        n_checks++;
        if (plog.size() != 3) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d pushes, required 3", plog.size());
        end else begin
            n_checks++;
            if (plog[0].push !== 4'b0001 || plog[0].data !== 32'h60 || plog[0].sof !== 1'b1 || plog[2].data !== 32'h70) begin
                n_fail++;
                $display("FAIL midrst_first: push=%b data=%h sof=%b, required push=0001 data=60 sof=1", plog[0].push, plog[0].data, plog[0].sof);
            end
        end
    endtask

    task automatic test_ovf_clear();
        clear_all();
        send_pkt(1, 32'h40, 2);
        for (int c = 0; c < 10 && FB_PKfbPush == 4'b0000; c++) tick();
        n_checks++;
        if (FB_PKfbPush !== 4'b0010) begin
            n_fail++;
            $display("FAIL clr_wait: push=%b, required 0010 within budget", FB_PKfbPush);
        end
        FB_PKfbOverflow = 1'b1;
        ovf_clr = 4'b0010;
        tick();
        FB_PKfbOverflow = 1'b0;
        ovf_clr = 4'b0000;
        n_checks++;
        if (ovf_sticky !== 4'b0010) begin
            n_fail++;
            $display("FAIL clr_set_wins: got %b, required 0010", ovf_sticky);
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        n_checks++;
        if (ovf_sticky !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_clears: got %b, required 0000", ovf_sticky);
        end
        repeat (4) tick();
        n_checks++;
        if (plog.size() != 1 || drop_log.size() != 1 || drop_log[0].bits !== 4'b0010 || done_log.size() != 0) begin
            n_fail++;
            $display("FAIL clr_abort: pushes=%0d drops=%0d dones=%0d, required 1 1 0", plog.size(), drop_log.size(), done_log.size());
        end
    endtask

    initial begin
        rst             = 1'b1;
        req_valid       = 4'b0000;
        req_data        = '0;
        req_last        = 4'b0000;
        req_en          = 4'b1111;
        FB_PKfbOverflow = 1'b0;
        ovf_clr         = 4'b0000;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_overflow_abort();
        test_max_words();
        test_reset_midpacket();
        test_ovf_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pkfb_push_arbiter.md
Name: pkfb_push_arbiter

Overview:
- Shares the single 32-bit packet-FIFO push bus (FB_PKfbData/Push/SOF/EOF) between four fabric packet sources.
- Requester i is hard-mapped to packet FIFO i, i.e. FB_PKfbPush[i].
- Performs packet-atomic round-robin arbitration, generates SOF/EOF framing, enforces a maximum packet length, and traps FIFO overflow reported by the hard block.

Parameters:
- MAX_WORDS, 256: maximum words per pushed packet. Legal range 1..65535. Internal word counter is clog2(MAX_WORDS+1) bits.

Ports:
- Sys_PKfb_Clk  input  1  packet FIFO push clock; the only clock in the block.
- Sys_PKfb_Rst  input  1  reset, synchronous and active-high.
- req_valid  input  4  per-requester word valid.
- req_data  input  128  per-requester word; requester i uses bits [32i+31:32i].
- req_last  input  4  per-requester last word of packet.
- req_ready  output  4  per-requester word accept.
- req_en  input  4  per-requester arbitration enable.
- FB_PKfbData  output  32  push data to hard block.
- FB_PKfbPush  output  4  one-hot push strobe, bit i = FIFO i.
- FB_PKfbSOF  output  1  first word of packet.
- FB_PKfbEOF  output  1  last word of packet.
- FB_PKfbOverflow  input  1  hard-block overflow; combinational with the current FB_PKfbPush.
- ovf_clr  input  4  clears ovf_sticky bits.
- ovf_sticky  output  4  sticky overflow flag per FIFO.
- pkt_done  output  4  1-cycle pulse: packet fully pushed.
- pkt_drop  output  4  1-cycle pulse: packet truncated or aborted.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, rr_ptr=3 (so requester 0 has first priority), word count 0, ovf_sticky=0.
  - Reset mid-packet abandons the packet; no EOF is emitted.
- Word transfer and latency:
  - A word is accepted when req_valid[i] & req_ready[i].
  - req_ready[i] = (state!=IDLE) & (grant==i). It is decoded from registered state only and never depends on req_valid.
  - An accepted word appears on FB_PKfbData the next cycle with FB_PKfbPush=onehot(grant). Fixed latency: 1 cycle.
  - FB_PKfbPush/SOF/EOF are 0 in every cycle with no accepted word (XFER state only). Data holds its last value.
- FSM:
  - IDLE:
    - Candidates are i with req_valid[i] & req_en[i].
    - Search order is rr_ptr+1, rr_ptr+2, ... (mod 4).
    - On a hit: grant<=i, rr_ptr<=i, count<=0, go to XFER.
    - This costs a 1-cycle arbitration bubble per packet. No requester is ready while in IDLE.
  - XFER: each accepted word is registered to the outputs.
    - SOF=1 when count==0.
    - EOF=1 when req_last, or when count==MAX_WORDS-1.
    - count increments on each accepted word.
    - Accepted word with req_last: go to IDLE; pkt_done[grant] pulses the next cycle, aligned with the EOF push.
    - Word with count==MAX_WORDS-1 and no req_last: EOF is forced and the block goes to DROP.
  - DROP:
    - req_ready stays high for the grant; words are accepted and discarded (no push).
    - On req_last: go to IDLE and pulse pkt_drop[grant].
- Overflow:
  - Condition: FB_PKfbOverflow=1 while FB_PKfbPush!=0.
  - Effect: ovf_sticky[k]<=1, where k is the set Push bit.
  - If the overflowed push carried EOF: no further action.
  - Otherwise, if state is XFER for FIFO k:
    - Any word accepted in that same cycle is discarded.
    - State goes to DROP. If that discarded word had req_last, state goes to IDLE instead and pkt_drop[k] pulses.
  - The remainder of the aborted packet is dropped; no EOF is pushed for it.
- ovf_clr[k] clears ovf_sticky[k]. If set and clear occur in the same cycle, set wins.
- req_en[i] deasserted mid-packet has no effect until the packet ends; it only gates arbitration.
- req_valid may deassert mid-packet. Output bubbles follow, and SOF/EOF framing is preserved.
- pkt_done and pkt_drop are never asserted together for the same packet.

Test Plan:
1. Requester 0 sends 3 words 0xA0,0xA1,0xA2 back-to-back after reset -> Push=0001 on 3 consecutive cycles; SOF on 0xA0 only; EOF on 0xA2 only; pkt_done=0001 pulses once, aligned with EOF.
2. Requesters 0 and 2 continuously offer 2-word packets -> grant order 0,2,0,2; packets never interleave; 1 idle cycle between packets; Push alternates 0001/0100.
3. Requester 1 sends a 4-word packet; FB_PKfbOverflow=1 during the 2nd push -> ovf_sticky=0010; words 3 and 4 accepted but not pushed; pkt_drop=0010 pulses. Next requester-1 packet pushes normally with SOF.
4. MAX_WORDS=4, requester 3 sends 6 words -> 4 pushes with Push=1000, EOF on the 4th; words 5 and 6 consumed silently; pkt_drop=1000 pulses.
5. Sys_PKfb_Rst asserted during word 2 of a 5-word packet -> next cycle Push/SOF/EOF/req_ready/ovf_sticky all 0. After reset release, requester 0 wins first with a fresh SOF.
6. ovf_clr[1]=1 in the same cycle as an overflow on FIFO 1 -> ovf_sticky[1] stays 1. An ovf_clr[1] pulse a cycle later -> 0.
